pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
- Sequences the video-clock PLL: drives its reset, qualifies its lock output, and releases the downstream core reset only after the lock has been stable.
- Retries a PLL that fails to lock, recovers from lock loss during operation, and supports a software-requested relock (e.g. after a video-mode change).
- Runs on the 50 MHz PLL reference clock. Sits between the PLL instance and the video core's reset input.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 500000: max consecutive cycles in WAIT_LOCK without lock before retry (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive qualified-lock cycles required before release.
- MAX_RETRIES, 4: failed attempts (timeout or lock drop during qualification) before FAULT (>=1).
- CNT_W, 8: width of diagnostic counters.

Ports:
- refclk, in, 1: the single clock; all logic on its rising edge.
- rst, in, 1: reset; synchronous, active-high.
- locked, in, 1: PLL lock, asynchronous to refclk.
- relock_req, in, 1: synchronous request to re-run the full sequence.
- pll_rst, out, 1: reset to the PLL.
- core_rst, out, 1: reset to the downstream core; equals ~ready.
- ready, out, 1: PLL locked and qualified; core may run.
- fault, out, 1: retry budget exhausted.
- retry_cnt, out, CNT_W: total failed attempts since rst; saturating.
- loss_cnt, out, CNT_W: lock losses while in RUN since rst; saturating.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Locked synchroniser
  - locked passes through a 2-flop synchroniser to produce locked_s. Only locked_s is used.
  - locked_s lags locked by 2 edges.
- Registered outputs
  - All outputs are registered and decoded from the next state, so outputs change on the same edge as state.
- Reset (rst=1 at an edge)
  - state=RESET, timer=0, attempts=0, synchroniser flops=0.
  - pll_rst=1, core_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, state_dbg=0.
- States and encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- Priority at each edge: rst > relock_req > state transitions.
- RESET
  - pll_rst=1.
  - timer counts; after RST_CYCLES cycles in RESET, go to WAIT_LOCK and clear the timer.
  - relock_req is ignored in this state.
- WAIT_LOCK
  - pll_rst=0.
  - If locked_s=1, go to STABLE and clear the timer.
  - Else, if LOCK_TIMEOUT consecutive cycles have elapsed, count a failure (see Failure).
- STABLE
  - pll_rst=0.
  - Count cycles with locked_s=1; after STABLE_CYCLES cycles, go to RUN.
  - If locked_s=0 first, count a failure.
- Failure
  - attempts++ and retry_cnt++ (saturating at 2^CNT_W-1).
  - If attempts==MAX_RETRIES, go to FAULT; else go to RESET.
- RUN
  - ready=1, core_rst=0, attempts cleared.
  - If locked_s=0: loss_cnt++ (saturating), go to RESET; ready drops on that same edge.
  - A loss in RUN does not count as an attempt.
- FAULT
  - pll_rst=1, core_rst=1, fault=1.
  - Exited only by rst or relock_req.
- relock_req=1 in any state except RESET
  - Next state=RESET, attempts=0, timer=0, fault cleared.
  - Diagnostic counters are not changed.
- A single-cycle locked glitch shorter than a refclk period may be missed by the synchroniser. This is acceptable.
- Timer width is sized to max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). Wrap-around is not possible because the timer is cleared on every state entry.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2; edges counted from the first edge with rst=0):
- Normal bring-up:
  - Stimulus: rst released; locked rises right after pll_rst falls.
  - Required: pll_rst=1 for edges 1-4, falls after edge 4; ready=1 and core_rst=0 after the 11th edge following the locked rise; retry_cnt=0.
- No lock:
  - Stimulus: locked held at 0.
  - Required: pll_rst high for 4 cycles, low for 100 cycles, high for 4, low for 100; fault=1 after edge 208; retry_cnt=2; pll_rst stays 1 thereafter.
- Glitch during qualification:
  - Stimulus: locked high for 5 cycles, low, then stays high after the next reset pulse.
  - Required: return to RESET with retry_cnt=1; second qualification reaches RUN; fault never set.
- Loss in RUN:
  - Stimulus: from RUN, drop locked.
  - Required: ready falls 3 edges after the drop; pll_rst pulses for 4 cycles; loss_cnt=1; re-lock returns to RUN; attempts cleared.
- Relock request:
  - Stimulus: relock_req pulse in RUN, then in FAULT.
  - Required: next edge state_dbg=0, ready=0, pll_rst=1; from FAULT, fault clears and retry_cnt is unchanged.
- Reset mid-operation:
  - Stimulus: rst asserted during STABLE and during RUN.
  - Required: next edge all outputs at reset values; counters zero.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Video PLL sequencer: pulses pll_rst, qualifies a synchronised lock, retries, and gates the core reset.
// Latency: locked reaches the FSM after 2 refclk edges; every output is registered on the state edge. No backpressure.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             core_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state_dbg
);

    localparam int T_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int TIMER_W = $clog2(T_MAX + 1);
    localparam int ATT_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [2:0]         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [ATT_W-1:0]   attempts, attempts_nxt;
    logic               fail, retry_inc, loss_inc;
    logic               locked_q1, locked_s;

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        attempts_nxt = attempts;
        fail         = 1'b0;
        retry_inc    = 1'b0;
        loss_inc     = 1'b0;
        if (relock_req && state != S_RESET) begin
            state_nxt    = S_RESET;
            timer_nxt    = '0;
            attempts_nxt = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (timer == TIMER_W'(RST_CYCLES - 1)) begin
                        state_nxt = S_WAIT_LOCK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        timer_nxt = '0;
                    end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        fail = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        fail = 1'b1;
                    end else if (timer == TIMER_W'(STABLE_CYCLES - 1)) begin
                        state_nxt = S_RUN;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                S_RUN: begin
                    attempts_nxt = '0;
                    if (!locked_s) begin
                        loss_inc  = 1'b1;
                        state_nxt = S_RESET;
                        timer_nxt = '0;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_RESET;
                    timer_nxt = '0;
                end
            endcase
            // A failed attempt either re-pulses the PLL or gives up once the budget is spent.
            if (fail) begin
                retry_inc    = 1'b1;
                attempts_nxt = attempts + 1'b1;
                timer_nxt    = '0;
                state_nxt    = (attempts_nxt == ATT_W'(MAX_RETRIES)) ? S_FAULT : S_RESET;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_q1 <= 1'b0;
            locked_s  <= 1'b0;
            state     <= S_RESET;
            timer     <= '0;
            attempts  <= '0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            state_dbg <= S_RESET;
        end else begin
            locked_q1 <= locked;
            locked_s  <= locked_q1;
            state     <= state_nxt;
            timer     <= timer_nxt;
            attempts  <= attempts_nxt;
            pll_rst   <= (state_nxt == S_RESET) || (state_nxt == S_FAULT);
            core_rst  <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            fault     <= (state_nxt == S_FAULT);
            state_dbg <= state_nxt;
            if (retry_inc && retry_cnt != '1)
                retry_cnt <= retry_cnt + 1'b1;
            if (loss_inc && loss_cnt != '1)
                loss_cnt <= loss_cnt + 1'b1;
        end
    end

endmodule
